// File: rtl/pipe_pkg.sv
// Shared pipeline package: opcode constants, operand-forward encodings,
// hazard-controller FSM state type and the destination-register decode
// used by both the hazard controller and the ALU write-register logic.
package pipe_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;
  localparam int unsigned CNT_W = 3;

  localparam logic [OP_W-1:0] OP_R    = 6'd0;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd1;
  localparam logic [OP_W-1:0] OP_LW   = 6'd16;
  localparam logic [OP_W-1:0] OP_LH   = 6'd18;
  localparam logic [OP_W-1:0] OP_LB   = 6'd20;
  localparam logic [OP_W-1:0] OP_SW   = 6'd24;
  localparam logic [OP_W-1:0] OP_SH   = 6'd26;
  localparam logic [OP_W-1:0] OP_SB   = 6'd28;
  localparam logic [OP_W-1:0] OP_JAL  = 6'd41;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  // Operand select: register file, EX result, WB result
  localparam logic [FWD_W-1:0] FWD_RF = 2'd0;
  localparam logic [FWD_W-1:0] FWD_EX = 2'd1;
  localparam logic [FWD_W-1:0] FWD_WB = 2'd2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LDWAIT = 1'b1
  } hz_state_e;

  // Register written by an instruction; 0 means it writes nothing
  function automatic logic [REG_W-1:0] dest_of(input logic [OP_W-1:0]  op,
                                               input logic [REG_W-1:0] rt,
                                               input logic [REG_W-1:0] rd);
    logic [REG_W-1:0] d;
    d = REG_ZERO;
    case (op)
      OP_R:                                    d = rd;
      OP_ADDI, 6'd3, 6'd4, 6'd5, 6'd6,
      OP_LW, OP_LH, OP_LB:                     d = rt;
      OP_JAL:                                  d = REG_RA;
      default:                                 d = REG_ZERO;
    endcase
    return d;
  endfunction

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline (master) and the
// controller (slave).
//   master drives : id_valid, id_op, id_rs, id_rt, id_rd, ex_valid, ex_op,
//                   ex_redirect
//   slave drives  : pc_en, id_en, ex_en, ex_bubble, id_flush, fwd_s, fwd_t,
//                   ex_dest, wb_dest, wb_we
interface ex_hazard_ctrl_if;
  import pipe_pkg::*;

  logic             id_valid;
  logic [OP_W-1:0]  id_op;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             ex_valid;
  logic [OP_W-1:0]  ex_op;
  logic             ex_redirect;

  logic             pc_en;
  logic             id_en;
  logic             ex_en;
  logic             ex_bubble;
  logic             id_flush;
  logic [FWD_W-1:0] fwd_s;
  logic [FWD_W-1:0] fwd_t;
  logic [REG_W-1:0] ex_dest;
  logic [REG_W-1:0] wb_dest;
  logic             wb_we;

  modport master (
    output id_valid, id_op, id_rs, id_rt, id_rd, ex_valid, ex_op, ex_redirect,
    input  pc_en, id_en, ex_en, ex_bubble, id_flush, fwd_s, fwd_t,
           ex_dest, wb_dest, wb_we
  );

  modport slave (
    input  id_valid, id_op, id_rs, id_rt, id_rd, ex_valid, ex_op, ex_redirect,
    output pc_en, id_en, ex_en, ex_bubble, id_flush, fwd_s, fwd_t,
           ex_dest, wb_dest, wb_we
  );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_sel.sv
// fwd_sel: combinational per-operand forward comparator.
//   src_i     : source register read by the ID instruction
//   ex_dest_i : destination tracked in EX
//   wb_dest_i : destination tracked in WB
//   fwd_c_o   : FWD_EX / FWD_WB / FWD_RF, EX wins over WB, r0 never matches
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] ex_dest_i,
  input  logic [REG_W-1:0] wb_dest_i,
  output logic [FWD_W-1:0] fwd_c_o
);

  always_comb begin
    fwd_c_o = FWD_RF;
    if (src_i != REG_ZERO && src_i == ex_dest_i) begin
      fwd_c_o = FWD_EX;
    end else if (src_i != REG_ZERO && src_i == wb_dest_i) begin
      fwd_c_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: execute-stage interlock and forwarding controller.
// Tracks EX/WB destination registers, freezes PC/IF-ID/ID-EX while a load
// waits DM_LAT cycles on data memory, flushes IF/ID on an EX redirect and
// drives the ALU operand forward selects.
//   clk, rst_n : clock, asynchronous active-low reset
//   hz_if      : ex_hazard_ctrl_if.slave bundle (ID/EX inputs, enables,
//                bubble/flush, forward selects, tracked destinations)
//   DM_LAT     : data-memory read latency, 1..7
// Build option HAZARD_FWD_EN: when defined, operands are forwarded; when
// undefined, fwd_s/fwd_t stay 0 and a dependent ID instruction is stalled
// with bubbles until its sources leave EX and WB.
module ex_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DM_LAT = 3
) (
  input logic             clk,
  input logic             rst_n,
  ex_hazard_ctrl_if.slave hz_if
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;
  logic [REG_W-1:0] wb_dest_q, wb_dest_d;

  logic [FWD_W-1:0] sel_s_c, sel_t_c;
  logic             stall_c;
  logic             ex_load_c;
  logic             advance_c;
  logic             pc_en_c, id_en_c, ex_en_c, ex_bubble_c, id_flush_c;

  // Per-source comparators against the tracked destinations
  fwd_sel u_fwd_s (
    .src_i     (hz_if.id_rs),
    .ex_dest_i (ex_dest_q),
    .wb_dest_i (wb_dest_q),
    .fwd_c_o   (sel_s_c)
  );

  fwd_sel u_fwd_t (
    .src_i     (hz_if.id_rt),
    .ex_dest_i (ex_dest_q),
    .wb_dest_i (wb_dest_q),
    .fwd_c_o   (sel_t_c)
  );

`ifdef HAZARD_FWD_EN
  assign stall_c     = 1'b0;
  assign hz_if.fwd_s = sel_s_c;
  assign hz_if.fwd_t = sel_t_c;
`else
  // Without forwarding any live dependence becomes a bubble
  assign stall_c     = hz_if.id_valid && ((sel_s_c != FWD_RF) || (sel_t_c != FWD_RF));
  assign hz_if.fwd_s = FWD_RF;
  assign hz_if.fwd_t = FWD_RF;
`endif

  assign ex_load_c = hz_if.ex_valid && is_load(hz_if.ex_op);

  // Next-state and enable decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ex_dest_d   = ex_dest_q;
    wb_dest_d   = wb_dest_q;
    pc_en_c     = 1'b1;
    id_en_c     = 1'b1;
    ex_en_c     = 1'b1;
    ex_bubble_c = 1'b0;
    id_flush_c  = 1'b0;
    advance_c   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_load_c) begin
          // Load wins over a coincident redirect
          pc_en_c   = 1'b0;
          id_en_c   = 1'b0;
          ex_en_c   = 1'b0;
          wb_dest_d = REG_ZERO;
          cnt_d     = CNT_W'(1);
          state_d   = ST_LDWAIT;
        end else if (hz_if.ex_redirect) begin
          // Kill the wrong-path ID instruction; new PC still loads
          id_flush_c  = 1'b1;
          ex_bubble_c = 1'b1;
          ex_dest_d   = REG_ZERO;
          wb_dest_d   = ex_dest_q;
        end else begin
          advance_c = 1'b1;
        end
      end
      ST_LDWAIT: begin
        if (cnt_q < CNT_W'(DM_LAT)) begin
          pc_en_c   = 1'b0;
          id_en_c   = 1'b0;
          ex_en_c   = 1'b0;
          wb_dest_d = REG_ZERO;
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
          advance_c = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // Normal pipeline advance, possibly turned into a bubble by a stall
    if (advance_c) begin
      wb_dest_d = ex_dest_q;
      if (stall_c) begin
        pc_en_c     = 1'b0;
        id_en_c     = 1'b0;
        ex_bubble_c = 1'b1;
        ex_dest_d   = REG_ZERO;
      end else if (hz_if.id_valid) begin
        ex_dest_d = dest_of(hz_if.id_op, hz_if.id_rt, hz_if.id_rd);
      end else begin
        ex_dest_d = REG_ZERO;
      end
    end
  end

  // State and destination tracking registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      ex_dest_q <= REG_ZERO;
      wb_dest_q <= REG_ZERO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ex_dest_q <= ex_dest_d;
      wb_dest_q <= wb_dest_d;
    end
  end

  assign hz_if.pc_en     = pc_en_c;
  assign hz_if.id_en     = id_en_c;
  assign hz_if.ex_en     = ex_en_c;
  assign hz_if.ex_bubble = ex_bubble_c;
  assign hz_if.id_flush  = id_flush_c;
  assign hz_if.ex_dest   = ex_dest_q;
  assign hz_if.wb_dest   = wb_dest_q;
  assign hz_if.wb_we     = (wb_dest_q != REG_ZERO);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl with DM_LAT=3. A behavioural model tracks the
// EX/WB destinations and how long the current EX instruction has sat in EX;
// it is checked against every DUT output each cycle, and directed literal
// expectations pin the model for both HAZARD_FWD_EN builds.
module tb_ex_hazard_ctrl;

  localparam int unsigned DM = 3;

  logic clk = 1'b0;
  logic rst_n;

  ex_hazard_ctrl_if hz_if();

  ex_hazard_ctrl #(.DM_LAT(DM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz_if (hz_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en;
    logic       id_en;
    logic       ex_en;
    logic       ex_bubble;
    logic       id_flush;
    logic [1:0] fwd_s;
    logic [1:0] fwd_t;
    logic [4:0] ex_dest;
    logic [4:0] wb_dest;
    logic       wb_we;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ex  = 0;
  int m_wb  = 0;
  int m_age = 0;

  function automatic int ref_dest(input int op, input int rt, input int rd);
    if (op == 0) return rd;
    if (op inside {1, 3, 4, 5, 6, 16, 18, 20}) return rt;
    if (op == 41) return 31;
    return 0;
  endfunction

  function automatic bit ref_load(input int op);
    return op inside {16, 18, 20};
  endfunction

  function automatic int ref_fwd(input int src);
    if (src != 0 && src == m_ex) return 1;
    if (src != 0 && src == m_wb) return 2;
    return 0;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    bit   ld, frozen, hit;
    int   fs, ft;
    ld     = hz_if.ex_valid && ref_load(int'(hz_if.ex_op));
    frozen = ld && (m_age < int'(DM));
    fs     = ref_fwd(int'(hz_if.id_rs));
    ft     = ref_fwd(int'(hz_if.id_rt));
    hit    = hz_if.id_valid && (fs != 0 || ft != 0);
    e = '0;
    e.pc_en = 1'b1;
    e.id_en = 1'b1;
    e.ex_en = 1'b1;
    if (frozen) begin
      e.pc_en = 1'b0;
      e.id_en = 1'b0;
      e.ex_en = 1'b0;
    end else if (hz_if.ex_redirect && !ld) begin
      e.ex_bubble = 1'b1;
      e.id_flush  = 1'b1;
    end
`ifndef HAZARD_FWD_EN
    else if (hit) begin
      e.pc_en     = 1'b0;
      e.id_en     = 1'b0;
      e.ex_bubble = 1'b1;
    end
`endif
`ifdef HAZARD_FWD_EN
    e.fwd_s = 2'(fs);
    e.fwd_t = 2'(ft);
`else
    if (hit) e.fwd_s = 2'd0;
`endif
    e.ex_dest = 5'(m_ex);
    e.wb_dest = 5'(m_wb);
    e.wb_we   = (m_wb != 0);
    return e;
  endfunction

  task automatic model_update();
    obs_t e;
    bit   ld;
    if (!rst_n) begin
      m_ex = 0; m_wb = 0; m_age = 0;
      return;
    end
    ld = hz_if.ex_valid && ref_load(int'(hz_if.ex_op));
    if (ld && m_age < int'(DM)) begin
      m_wb = 0;
      m_age++;
    end else begin
      e     = model_out();
      m_wb  = m_ex;
      m_ex  = (e.ex_bubble || !hz_if.id_valid) ? 0 :
              ref_dest(int'(hz_if.id_op), int'(hz_if.id_rt), int'(hz_if.id_rd));
      m_age = 0;
    end
  endtask

  task automatic model_check();
    obs_t e, a;
    e = model_out();
    a.pc_en     = hz_if.pc_en;
    a.id_en     = hz_if.id_en;
    a.ex_en     = hz_if.ex_en;
    a.ex_bubble = hz_if.ex_bubble;
    a.id_flush  = hz_if.id_flush;
    a.fwd_s     = hz_if.fwd_s;
    a.fwd_t     = hz_if.fwd_t;
    a.ex_dest   = hz_if.ex_dest;
    a.wb_dest   = hz_if.wb_dest;
    a.wb_we     = hz_if.wb_we;
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL model t=%0t got en=%b%b%b bub=%b fl=%b fs=%0d ft=%0d exd=%0d wbd=%0d we=%b, expected en=%b%b%b bub=%b fl=%b fs=%0d ft=%0d exd=%0d wbd=%0d we=%b",
               $time, a.pc_en, a.id_en, a.ex_en, a.ex_bubble, a.id_flush, a.fwd_s, a.fwd_t,
               a.ex_dest, a.wb_dest, a.wb_we, e.pc_en, e.id_en, e.ex_en, e.ex_bubble,
               e.id_flush, e.fwd_s, e.fwd_t, e.ex_dest, e.wb_dest, e.wb_we);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic set_id(input bit v, input int op, input int rs, input int rt, input int rd);
    hz_if.id_valid = v;
    hz_if.id_op    = 6'(op);
    hz_if.id_rs    = 5'(rs);
    hz_if.id_rt    = 5'(rt);
    hz_if.id_rd    = 5'(rd);
  endtask

  task automatic set_ex(input bit v, input int op, input bit redir);
    hz_if.ex_valid    = v;
    hz_if.ex_op       = 6'(op);
    hz_if.ex_redirect = redir;
  endtask

  task automatic cyc(input bit iv, input int iop, input int rs, input int rt, input int rd,
                     input bit ev, input int eop, input bit redir);
    next();
    set_id(iv, iop, rs, rt, rd);
    set_ex(ev, eop, redir);
    sample();
  endtask

  task automatic reset_lits(input string tag);
    lit({tag, "_pc_en"},     int'(hz_if.pc_en), 1);
    lit({tag, "_id_en"},     int'(hz_if.id_en), 1);
    lit({tag, "_ex_en"},     int'(hz_if.ex_en), 1);
    lit({tag, "_ex_bubble"}, int'(hz_if.ex_bubble), 0);
    lit({tag, "_id_flush"},  int'(hz_if.id_flush), 0);
    lit({tag, "_fwd_s"},     int'(hz_if.fwd_s), 0);
    lit({tag, "_fwd_t"},     int'(hz_if.fwd_t), 0);
    lit({tag, "_wb_we"},     int'(hz_if.wb_we), 0);
    lit({tag, "_ex_dest"},   int'(hz_if.ex_dest), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0);
    set_ex(0, 0, 0);
    sample();
    reset_lits("rst");
    next();
    rst_n = 1'b1;

    // EX forwarding: producer rd=5, then consumer rs=5
    set_id(1, 0, 1, 2, 5); set_ex(0, 0, 0); sample();
    lit("c1_ex_dest", int'(hz_if.ex_dest), 0);
    cyc(1, 0, 5, 0, 6, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    lit("c2_fwd_s", int'(hz_if.fwd_s), 1);
    lit("c2_fwd_t", int'(hz_if.fwd_t), 0);
    lit("c2_pc_en", int'(hz_if.pc_en), 1);
`else
    lit("c2_pc_en", int'(hz_if.pc_en), 0);
    lit("c2_bubble", int'(hz_if.ex_bubble), 1);
`endif
    // Store reading rt=5 while the producer is in WB
    cyc(1, 24, 0, 5, 0, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    lit("c3_fwd_t", int'(hz_if.fwd_t), 2);
`else
    lit("c3_pc_en", int'(hz_if.pc_en), 0);
`endif
    cyc(1, 0, 3, 4, 5, 1, 24, 0);
    lit("c4_pc_en", int'(hz_if.pc_en), 1);
    cyc(1, 0, 3, 4, 5, 1, 0, 0);
    // ex_dest=wb_dest=5: EX has priority
    cyc(1, 24, 0, 5, 0, 1, 0, 0);
    lit("c6_ex_dest", int'(hz_if.ex_dest), 5);
    lit("c6_wb_dest", int'(hz_if.wb_dest), 5);
`ifdef HAZARD_FWD_EN
    lit("c6_fwd_t", int'(hz_if.fwd_t), 1);
`else
    lit("c6_bubble", int'(hz_if.ex_bubble), 1);
`endif

    // Load freeze for DM cycles, then advance
    cyc(1, 0, 0, 0, 4, 0, 0, 0);
    cyc(1, 16, 1, 8, 0, 1, 0, 0);
    cyc(1, 0, 8, 2, 3, 1, 16, 0);
    lit("ld1_pc_en", int'(hz_if.pc_en), 0);
    lit("ld1_id_en", int'(hz_if.id_en), 0);
    lit("ld1_ex_en", int'(hz_if.ex_en), 0);
    lit("ld1_wb_we", int'(hz_if.wb_we), 1);
    lit("ld1_bubble", int'(hz_if.ex_bubble), 0);
    cyc(1, 0, 8, 2, 3, 1, 16, 0);
    lit("ld2_wb_we", int'(hz_if.wb_we), 0);
    lit("ld2_pc_en", int'(hz_if.pc_en), 0);
    cyc(1, 0, 8, 2, 3, 1, 16, 0);
    lit("ld3_pc_en", int'(hz_if.pc_en), 0);
    cyc(1, 0, 8, 2, 3, 1, 16, 0);
    lit("ld4_ex_en", int'(hz_if.ex_en), 1);
`ifdef HAZARD_FWD_EN
    lit("ld4_pc_en", int'(hz_if.pc_en), 1);
    lit("ld4_fwd_s", int'(hz_if.fwd_s), 1);
`else
    lit("ld4_bubble", int'(hz_if.ex_bubble), 1);
    lit("ld4_pc_en", int'(hz_if.pc_en), 0);
`endif
    cyc(1, 0, 8, 0, 9, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    lit("ld5_fwd_s", int'(hz_if.fwd_s), 2);
`else
    lit("ld5_pc_en", int'(hz_if.pc_en), 0);
`endif
    cyc(1, 0, 0, 0, 0, 1, 0, 0);
    lit("c14_pc_en", int'(hz_if.pc_en), 1);

    // Back-to-back loads
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 18, 0);
      if (i == 0) lit("bb_a0_pc_en", int'(hz_if.pc_en), 0);
      if (i == 3) lit("bb_a3_pc_en", int'(hz_if.pc_en), 1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 20, 0);
      if (i == 0) lit("bb_b0_pc_en", int'(hz_if.pc_en), 0);
      if (i == 3) lit("bb_b3_pc_en", int'(hz_if.pc_en), 1);
    end

    // Redirect kills ID instruction rd=7
    cyc(1, 0, 0, 0, 7, 1, 41, 1);
    lit("rd_flush", int'(hz_if.id_flush), 1);
    lit("rd_bubble", int'(hz_if.ex_bubble), 1);
    lit("rd_pc_en", int'(hz_if.pc_en), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    lit("rd_next_ex_dest", int'(hz_if.ex_dest), 0);
    lit("rd_next_flush", int'(hz_if.id_flush), 0);
    // Redirect beats a dependence stall
    cyc(1, 0, 0, 0, 9, 0, 0, 0);
    cyc(1, 0, 9, 0, 1, 1, 41, 1);
    lit("rs_pc_en", int'(hz_if.pc_en), 1);
    lit("rs_flush", int'(hz_if.id_flush), 1);
    lit("rs_bubble", int'(hz_if.ex_bubble), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Load with redirect asserted: load wins throughout
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 11, 1, 16, 1);
      if (i == 0) begin
        lit("lr0_flush", int'(hz_if.id_flush), 0);
        lit("lr0_pc_en", int'(hz_if.pc_en), 0);
      end
      if (i == 3) begin
        lit("lr3_flush", int'(hz_if.id_flush), 0);
        lit("lr3_pc_en", int'(hz_if.pc_en), 1);
      end
    end

    // Reset during the second LDWAIT cycle
    cyc(1, 0, 11, 0, 2, 1, 16, 0);
    cyc(1, 0, 11, 0, 2, 1, 16, 0);
    lit("pre_rst_ex_dest", int'(hz_if.ex_dest), 11);
    next();
    rst_n = 1'b0;
    m_ex = 0; m_wb = 0; m_age = 0;
    set_id(0, 0, 0, 0, 0);
    set_ex(0, 0, 0);
    sample();
    reset_lits("mid_rst");
    next();
    rst_n = 1'b1;
    sample();
    lit("post_rst_pc_en", int'(hz_if.pc_en), 1);
    lit("post_rst_ex_en", int'(hz_if.ex_en), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 16, 0);
      if (i == 0) lit("prl0_pc_en", int'(hz_if.pc_en), 0);
      if (i == 3) lit("prl3_pc_en", int'(hz_if.pc_en), 1);
    end

    // Consumer of r9 held in ID for three cycles
    cyc(1, 0, 0, 0, 9, 0, 0, 0);
    cyc(1, 0, 9, 0, 1, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    lit("h0_fwd_s", int'(hz_if.fwd_s), 1);
`else
    lit("h0_pc_en", int'(hz_if.pc_en), 0);
`endif
    cyc(1, 0, 9, 0, 1, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    lit("h1_fwd_s", int'(hz_if.fwd_s), 2);
`else
    lit("h1_bubble", int'(hz_if.ex_bubble), 1);
`endif
    cyc(1, 0, 9, 0, 1, 1, 0, 0);
    lit("h2_pc_en", int'(hz_if.pc_en), 1);
    lit("h2_fwd_s", int'(hz_if.fwd_s), 0);

    next();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
